// File: rtl/dvp_tx_pkg.sv
// Shared types for the DVP camera transmitter.
// Frame phases and the byte-order helper used by the output mux.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  localparam bit HI_FIRST = 1'b1;

  function automatic logic [7:0] pick_byte(
    input logic [15:0] pix,
    input logic        second
  );
    return (second ^ !HI_FIRST) ? pix[7:0] : pix[15:8];
  endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// DVP frame timing: byte phase, line/column counters and frame FSM.
// Sync outputs move only at the end of a byte slot (ph 1 -> 0).
module dvp_tx_timing
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE     = 1280,
  parameter int H_BLANK      = 64,
  parameter int V_ACTIVE     = 720,
  parameter int VSYNC_LINES  = 4,
  parameter int VBACK_LINES  = 16,
  parameter int VFRONT_LINES = 4,
  parameter bit VSYNC_POL    = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  output logic ph,
  output logic href,
  output logic vsync,
  output logic fetch,
  output logic first,
  output logic frame_done,
  output logic resync,
  output logic busy
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int CW   = $clog2(LINE + 1);
  localparam int LSUM = V_ACTIVE + VSYNC_LINES
                      + VBACK_LINES + VFRONT_LINES;
  localparam int LW   = $clog2(LSUM + 1);

  state_t          state;
  state_t          n_state;
  logic [CW-1:0]   col;
  logic [CW-1:0]   n_col;
  logic [LW-1:0]   row;
  logic [LW-1:0]   n_row;
  logic [LW-1:0]   lines;
  logic            last_col;
  logic            last_row;
  logic            pix_next;
  logic            frame_end;

  always_comb begin
    unique case (state)
      VSYNC:   lines = LW'(VSYNC_LINES);
      VBACK:   lines = LW'(VBACK_LINES);
      ACTIVE:  lines = LW'(V_ACTIVE);
      VFRONT:  lines = LW'(VFRONT_LINES);
      default: lines = LW'(1);
    endcase
  end

  assign last_col = (col == CW'(LINE - 1));
  assign last_row = (row == lines - 1'b1);

  // Position of the slot that follows the current one.
  always_comb begin
    n_state = state;
    n_col   = col + 1'b1;
    n_row   = row;
    if (state == IDLE) begin
      n_col = '0;
      if (enable) n_state = VSYNC;
    end else if (last_col) begin
      n_col = '0;
      n_row = row + 1'b1;
      if (last_row) begin
        n_row = '0;
        unique case (state)
          VSYNC:   n_state = VBACK;
          VBACK:   n_state = ACTIVE;
          ACTIVE:  n_state = VFRONT;
          default: n_state = enable ? VSYNC : IDLE;
        endcase
      end
    end
  end

  // Next slot carries the high byte of an active pixel.
  assign pix_next  = (n_state == ACTIVE)
                   && (n_col < CW'(2 * H_ACTIVE))
                   && !n_col[0];
  assign frame_end = (state == VFRONT) && last_col && last_row;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph         <= 1'b0;
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      href       <= 1'b0;
      vsync      <= !VSYNC_POL;
      fetch      <= 1'b0;
      first      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ph         <= !ph;
      fetch      <= !ph && pix_next;
      first      <= !ph && pix_next
                    && (n_row == '0) && (n_col == '0);
      frame_done <= !ph && frame_end;
      if (ph) begin
        state <= n_state;
        col   <= n_col;
        row   <= n_row;
        href  <= (n_state == ACTIVE)
                 && (n_col < CW'(2 * H_ACTIVE));
        vsync <= (n_state == VSYNC) ? VSYNC_POL
                                    : !VSYNC_POL;
      end
    end
  end

  assign resync = (state == VSYNC) || (state == VBACK);
  assign busy   = (state != IDLE);

endmodule

// File: rtl/dvp_cam_tx.sv
// DVP camera emulator: RGB565 ready/valid stream in, 8-bit DVP out.
// Holds the pixel handshake, pixel register, byte mux and error pulses.
module dvp_cam_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE     = 1280,
  parameter int H_BLANK      = 64,
  parameter int V_ACTIVE     = 720,
  parameter int VSYNC_LINES  = 4,
  parameter int VBACK_LINES  = 16,
  parameter int VFRONT_LINES = 4,
  parameter bit VSYNC_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic        underflow,
  output logic        sof_err,
  output logic        busy
);

  logic        ph;
  logic        fetch;
  logic        first;
  logic        resync;
  logic        lo_next;
  logic [15:0] pix_q;
  logic [15:0] pix_in;

  dvp_tx_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE),
    .VSYNC_LINES (VSYNC_LINES),
    .VBACK_LINES (VBACK_LINES),
    .VFRONT_LINES(VFRONT_LINES),
    .VSYNC_POL   (VSYNC_POL)
  ) u_timing (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .ph        (ph),
    .href      (cam_href),
    .vsync     (cam_vsync),
    .fetch     (fetch),
    .first     (first),
    .frame_done(frame_done),
    .resync    (resync),
    .busy      (busy)
  );

  assign cam_pclk = ph;

  // Before the first fetch, non-sof pixels are drained so the
  // stream realigns on the next sof pixel.
  assign pix_ready = fetch
                   | (resync & pix_valid & !pix_sof);

  assign underflow = fetch & !pix_valid;
  assign sof_err   = fetch & pix_valid
                   & (first ? !pix_sof : pix_sof);

  assign pix_in = pix_valid ? pix_data : 16'h0000;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_q    <= 16'h0000;
      lo_next  <= 1'b0;
      cam_data <= 8'h00;
    end else if (ph) begin
      if (fetch) begin
        pix_q    <= pix_in;
        cam_data <= pick_byte(pix_in, 1'b0);
        lo_next  <= 1'b1;
      end else if (lo_next) begin
        cam_data <= pick_byte(pix_q, 1'b1);
        lo_next  <= 1'b0;
      end else begin
        cam_data <= 8'h00;
      end
    end
  end

endmodule
